// File: rtl/rgmii_tx_ddr_prep_if.sv
// GMII-side byte stream in, d1/d2 pairs out for the TXD, TX_CTL and TXC output DDR cells.
interface rgmii_tx_ddr_prep_if;
   logic [1:0] speed;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       gmii_clk_en;
   logic [3:0] txd_d1;
   logic [3:0] txd_d2;
   logic       ctl_d1;
   logic       ctl_d2;
   logic       txc_d1;
   logic       txc_d2;

   modport master (
      output speed, gmii_txd, gmii_tx_en, gmii_tx_er,
      input  gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2
   );

   modport slave (
      input  speed, gmii_txd, gmii_tx_en, gmii_tx_er,
      output gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2
   );
endinterface

// File: rtl/rgmii_tx_ddr_prep.sv
// RGMII transmit prep: 1000M sends a byte per clk on both edges; 10/100M divides clk
// to synthesise the forwarded clock and sends one nibble per RGMII period.
module rgmii_tx_ddr_prep #(
   parameter int DIV_100 = 5,
   parameter int DIV_10  = 50
) (
   input  logic                      clk,
   input  logic                      rst,
   rgmii_tx_ddr_prep_if.slave        bus
);
   typedef enum logic [1:0] {
      SPD_10   = 2'b00,
      SPD_100  = 2'b01,
      SPD_1000 = 2'b10
   } spd_e;

   localparam int DMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
   localparam int W    = $clog2(DMAX);
   localparam logic [W-1:0] LAST10  = W'(DIV_10 - 1);
   localparam logic [W-1:0] LAST100 = W'(DIV_100 - 1);
   localparam logic [W-1:0] HALF10  = W'(DIV_10 / 2);
   localparam logic [W-1:0] HALF100 = W'(DIV_100 / 2);
   localparam logic         ODD10   = (DIV_10 % 2) == 1;
   localparam logic         ODD100  = (DIV_100 % 2) == 1;

   spd_e         spd_q, spd_in, cur_q, cur_d, sel_spd;
   logic [W-1:0] pos_q, pos_d, last, half;
   logic         ph_q, ph_d, odd, restart;
   logic [7:0]   cap_q, cap_d;
   logic         en_q, en_d, er_q, er_d;
   logic         ce_q, ce_d;
   logic [3:0]   txd1_q, txd1_d, txd2_q, txd2_d, nib;
   logic         ctl1_q, ctl1_d, ctl2_q, ctl2_d;
   logic         txc1_q, txc1_d, txc2_q, txc2_d;

   assign spd_in = (bus.speed == 2'b11) ? SPD_1000 : spd_e'(bus.speed);

   always_comb begin
      restart = (spd_q != cur_q);
      cur_d   = spd_q;
      // On a restart the divider is loaded for the speed being entered.
      sel_spd = restart ? spd_q : cur_q;
      last    = LAST100;
      half    = HALF100;
      odd     = ODD100;
      if (sel_spd == SPD_10) begin
         last = LAST10;
         half = HALF10;
         odd  = ODD10;
      end
      pos_d  = pos_q;
      ph_d   = ph_q;
      cap_d  = cap_q;
      en_d   = en_q;
      er_d   = er_q;
      ce_d   = 1'b0;
      txd1_d = 4'h0;
      txd2_d = 4'h0;
      ctl1_d = 1'b0;
      ctl2_d = 1'b0;
      txc1_d = 1'b0;
      txc2_d = 1'b0;
      nib    = 4'h0;
      if (restart) begin
         pos_d = last;
         ph_d  = 1'b1;
         ce_d  = 1'b1;
      end else if (cur_q == SPD_1000) begin
         ce_d   = 1'b1;
         txd1_d = bus.gmii_txd[3:0];
         txd2_d = bus.gmii_txd[7:4];
         ctl1_d = bus.gmii_tx_en;
         ctl2_d = bus.gmii_tx_en ^ bus.gmii_tx_er;
         txc1_d = 1'b1;
      end else begin
         if (pos_q == last) begin
            pos_d = '0;
            ph_d  = ~ph_q;
         end else begin
            pos_d = pos_q + 1'b1;
         end
         // The cycle showing the last position of ph=1 is the one that strobed the MAC.
         if (pos_q == last && ph_q) begin
            cap_d = bus.gmii_txd;
            en_d  = bus.gmii_tx_en;
            er_d  = bus.gmii_tx_er;
         end
         ce_d   = (pos_d == last) && ph_d;
         nib    = ph_d ? cap_d[7:4] : cap_d[3:0];
         txd1_d = nib;
         txd2_d = nib;
         txc1_d = (pos_d < half) || ((pos_d == half) && odd);
         txc2_d = (pos_d < half);
         ctl1_d = txc1_d ? en_d : (en_d ^ er_d);
         ctl2_d = txc2_d ? en_d : (en_d ^ er_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spd_q  <= SPD_1000;
         cur_q  <= SPD_1000;
         pos_q  <= '0;
         ph_q   <= 1'b0;
         cap_q  <= 8'h00;
         en_q   <= 1'b0;
         er_q   <= 1'b0;
         ce_q   <= 1'b0;
         txd1_q <= 4'h0;
         txd2_q <= 4'h0;
         ctl1_q <= 1'b0;
         ctl2_q <= 1'b0;
         txc1_q <= 1'b0;
         txc2_q <= 1'b0;
      end else begin
         spd_q  <= spd_in;
         cur_q  <= cur_d;
         pos_q  <= pos_d;
         ph_q   <= ph_d;
         cap_q  <= cap_d;
         en_q   <= en_d;
         er_q   <= er_d;
         ce_q   <= ce_d;
         txd1_q <= txd1_d;
         txd2_q <= txd2_d;
         ctl1_q <= ctl1_d;
         ctl2_q <= ctl2_d;
         txc1_q <= txc1_d;
         txc2_q <= txc2_d;
      end
   end

   assign bus.gmii_clk_en = ce_q;
   assign bus.txd_d1      = txd1_q;
   assign bus.txd_d2      = txd2_q;
   assign bus.ctl_d1      = ctl1_q;
   assign bus.ctl_d2      = ctl2_q;
   assign bus.txc_d1      = txc1_q;
   assign bus.txc_d2      = txc2_q;
endmodule

// File: tb/tb_rgmii_tx_ddr_prep.sv
// Directed bench: 1000M bytes/errors, 100M and 10M nibble pacing, speed restart, async reset.
module tb_rgmii_tx_ddr_prep;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   rgmii_tx_ddr_prep_if bus ();

   rgmii_tx_ddr_prep #(.DIV_100(5), .DIV_10(50)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // {clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2}
   function automatic logic [12:0] mk(input logic ce, input logic [3:0] a, input logic [3:0] b,
                                      input logic c1, input logic c2, input logic t1, input logic t2);
      return {ce, a, b, c1, c2, t1, t2};
   endfunction

   task automatic chk(input string tag, input logic [12:0] exp);
      logic [12:0] o;
      o = {bus.gmii_clk_en, bus.txd_d1, bus.txd_d2, bus.ctl_d1, bus.ctl_d2, bus.txc_d1, bus.txc_d2};
      checks++;
      assert (o === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [1:0] s, input logic [7:0] d, input logic en, input logic er);
      bus.speed      = s;
      bus.gmii_txd   = d;
      bus.gmii_tx_en = en;
      bus.gmii_tx_er = er;
   endtask

   // 100M period patterns: txc per position, for a byte with en=1 and er as given
   logic [1:0]  txc5 [5];
   logic [12:0] exp100 [10];
   logic        t;
   logic [3:0]  nb;

   initial begin
      txc5 = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
      drv(2'b10, 8'h00, 1'b0, 1'b0);
      tick();
      chk("reset_idle", 13'h0);
      tick();
      rst = 1'b0;

      // 1000M
      drv(2'b10, 8'h5A, 1'b1, 1'b0);
      tick(); chk("g_5A", mk(1, 4'hA, 4'h5, 1, 1, 1, 0));
      drv(2'b10, 8'hC3, 1'b1, 1'b0);
      tick(); chk("g_C3", mk(1, 4'h3, 4'hC, 1, 1, 1, 0));
      drv(2'b10, 8'hFF, 1'b1, 1'b1);
      tick(); chk("g_err_en", mk(1, 4'hF, 4'hF, 1, 0, 1, 0));
      drv(2'b10, 8'h00, 1'b0, 1'b1);
      tick(); chk("g_err_noen", mk(1, 4'h0, 4'h0, 0, 1, 1, 0));
      // speed 11 behaves as 1000M: no restart
      drv(2'b11, 8'h12, 1'b1, 1'b0);
      tick(); chk("s11_a", mk(1, 4'h2, 4'h1, 1, 1, 1, 0));
      drv(2'b11, 8'h34, 1'b1, 1'b0);
      tick(); chk("s11_b", mk(1, 4'h4, 4'h3, 1, 1, 1, 0));

      // 1000M -> 100M: one more 1000M cycle while speed is registered, then the restart cycle
      drv(2'b01, 8'h77, 1'b1, 1'b0);
      tick(); chk("chg_last1000", mk(1, 4'h7, 4'h7, 1, 1, 1, 0));
      drv(2'b01, 8'h5A, 1'b1, 1'b0);
      tick(); chk("chg_restart", 13'h1000);

      // first 100M byte 0x5A, en=1 er=0: ctl is 1 on every half
      for (int k = 0; k < 10; k++) begin
         nb = (k < 5) ? 4'hA : 4'h5;
         exp100[k] = mk(k == 9, nb, nb, 1, 1, txc5[k % 5][1], txc5[k % 5][0]);
      end
      for (int k = 0; k < 10; k++) begin
         tick(); chk($sformatf("m100_5A_%0d", k), exp100[k]);
         if (k == 9) drv(2'b01, 8'hC3, 1'b1, 1'b1);
         else        drv(2'b01, 8'hEE, 1'b0, 1'b0);
      end
      // second byte 0xC3, en=1 er=1: ctl = en where txc=1, en^er=0 where txc=0
      for (int k = 0; k < 10; k++) begin
         nb = (k < 5) ? 4'h3 : 4'hC;
         exp100[k] = mk(k == 9, nb, nb, txc5[k % 5][1], txc5[k % 5][0],
                        txc5[k % 5][1], txc5[k % 5][0]);
      end
      for (int k = 0; k < 10; k++) begin
         tick(); chk($sformatf("m100_C3_%0d", k), exp100[k]);
         drv(2'b01, 8'h5A, 1'b1, 1'b0);
      end

      // async reset mid-period
      tick(); tick();
      rst = 1'b1;
      #1; chk("async_rst", 13'h0);
      tick(); chk("rst_hold", 13'h0);
      rst = 1'b0;
      tick(); chk("post_rst_1000", mk(1, 4'hA, 4'h5, 1, 1, 1, 0));
      tick(); chk("post_rst_restart", 13'h1000);
      tick(); chk("post_rst_100_k0", mk(0, 4'hA, 4'hA, 1, 1, 1, 1));

      // 100M -> 10M, byte 0x96 en=1 er=1
      drv(2'b00, 8'h96, 1'b1, 1'b1);
      tick();
      tick(); chk("m10_restart", 13'h1000);
      for (int k = 0; k < 100; k++) begin
         tick();
         t  = (k % 50) < 25;
         nb = (k < 50) ? 4'h6 : 4'h9;
         chk($sformatf("m10_%0d", k), mk(k == 99, nb, nb, t, t, t, t));
         drv(2'b00, 8'h00, 1'b0, 1'b0);
      end
      tick(); chk("m10_next_byte", mk(0, 4'h0, 4'h0, 0, 0, 1, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
